switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_pkg.sv | 18 +
 rtl/debounce_bit.sv | 66 ++++++
 rtl/switch_debouncer.sv | 46 ++++
 tb/tb_switch_debouncer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch debouncer.
//   SW_WIDTH          width of the board switch PIO input port
//   DEBOUNCE_DEFAULT  stable cycles required before a change is accepted (1 ms at 50 MHz)
//   cnt_width()       counter width able to hold 0 .. cycles-1
package switch_pkg;

  localparam int SW_WIDTH         = 18;
  localparam int DEBOUNCE_DEFAULT = 50000;

  // ceil(log2(cycles)), never less than 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, stability counter, stable
// register and registered edge pulses.
//   clk     rising-edge system clock
//   reset   synchronous, active-high
//   raw     asynchronous bouncing switch level
//   clean   debounced level
//   rise    one-cycle pulse when clean goes 0->1
//   fall    one-cycle pulse when clean goes 1->0
//   commit  high in the cycle before clean takes a new value; lets the parent
//           register a summary pulse aligned with rise/fall
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          at_max;

  assign differ = sync2 ^ stable;
  assign at_max = (cnt == CNT_MAX);
  // Commit is the only exit from counting, so the counter never wraps.
  assign commit = differ & at_max;
  assign clean  = stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Pulses load on the same edge as stable, so they coincide with the new level.
      rise  <= commit & sync2;
      fall  <= commit & ~sync2;
      if (!differ) begin
        cnt <= '0;
      end else if (at_max) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer feeding the switch PIO in_port.
//   clk       rising-edge system clock
//   reset     synchronous, active-high
//   sw_raw    asynchronous bouncing switch levels
//   sw_clean  debounced, synchronized levels
//   sw_rise   per-bit one-cycle pulse on clean 0->1
//   sw_fall   per-bit one-cycle pulse on clean 1->0
//   changed   one-cycle pulse whenever any bit commits (OR of rise and fall)
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  logic [WIDTH-1:0] commit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .commit(commit[i])
    );
  end

  // Registered from the per-bit commit strobes so it lands with sw_rise/sw_fall.
  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else       changed <= |commit;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed testbench for switch_debouncer with DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_switch_debouncer;

  localparam int W = 18;
  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         changed;

  int n_vec;
  int n_bad;
  logic [W-1:0] exp_clean;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .changed (changed)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_clean"},   32'(sw_clean), 32'(exp_clean));
    check({tag, "_rise"},    32'(sw_rise),  32'd0);
    check({tag, "_fall"},    32'(sw_fall),  32'd0);
    check({tag, "_changed"}, 32'(changed),  32'd0);
  endtask

  // sw_raw was just driven: the next edge samples it, and the new level
  // shows on sw_clean after the (N+2)th edge counting that sampling edge.
  task automatic expect_commit(input string tag, input logic [W-1:0] new_clean,
                               input logic [W-1:0] er, input logic [W-1:0] ef);
    for (int k = 1; k <= N + 1; k++) begin
      tick();
      check_quiet({tag, "_wait"});
    end
    tick();
    exp_clean = new_clean;
    check({tag, "_clean"},   32'(sw_clean), 32'(exp_clean));
    check({tag, "_rise"},    32'(sw_rise),  32'(er));
    check({tag, "_fall"},    32'(sw_fall),  32'(ef));
    check({tag, "_changed"}, 32'(changed),  32'd1);
    tick();
    check_quiet({tag, "_after"});
  endtask

  initial begin
    logic [W-1:0] exp_rise;
    logic         exp_chg;
    n_vec     = 0;
    n_bad     = 0;
    exp_clean = '0;
    reset     = 1'b1;
    sw_raw    = '0;

    // reset state
    tick();
    tick();
    check_quiet("reset");

    // bit 0 rises
    @(negedge clk);
    reset  = 1'b0;
    sw_raw = 18'h00001;
    expect_commit("bit0_rise", 18'h00001, 18'h00001, 18'h00000);

    // bit 3 bounces 0,1,0,1,0 with 2-cycle phases, then holds 1
    for (int p = 0; p < 5; p++) begin
      drive((p % 2 == 1) ? 18'h00009 : 18'h00001);
      tick();
      check_quiet("bounce");
      tick();
      check_quiet("bounce");
    end
    drive(18'h00009);
    expect_commit("bit3_rise", 18'h00009, 18'h00008, 18'h00000);

    // all high, then all low in one cycle
    drive(18'h3FFFF);
    expect_commit("all_rise", 18'h3FFFF, 18'h3FFF6, 18'h00000);
    drive(18'h00000);
    expect_commit("all_fall", 18'h00000, 18'h00000, 18'h3FFFF);

    // bit 5 pending change discarded by reset, then recommits
    drive(18'h00020);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("b5_pre");
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_quiet("b5_reset");
    @(negedge clk);
    reset = 1'b0;
    expect_commit("b5_recommit", 18'h00020, 18'h00020, 18'h00000);

    // bits 0 and 17 two cycles apart
    drive(18'h00021);
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) drive(18'h20021);
      tick();
      if (k == 6)      exp_clean = 18'h00021;
      else if (k == 8) exp_clean = 18'h20021;
      exp_rise = (k == 6) ? 18'h00001 : (k == 8) ? 18'h20000 : 18'h00000;
      exp_chg  = (k == 6) || (k == 8);
      check("pair_clean",   32'(sw_clean), 32'(exp_clean));
      check("pair_rise",    32'(sw_rise),  32'(exp_rise));
      check("pair_fall",    32'(sw_fall),  32'd0);
      check("pair_changed", 32'(changed),  32'(exp_chg));
    end

    // back to zero, then a 1-cycle glitch on every bit
    drive(18'h00000);
    expect_commit("clear", 18'h00000, 18'h00000, 18'h20021);
    drive(18'h3FFFF);
    tick();
    check_quiet("glitch");
    drive(18'h00000);
    for (int k = 0; k < 2 * N + 2; k++) begin
      tick();
      check_quiet("glitch");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
